// File: rtl/ptp_ts_collect_pkg.sv
// Shared widths, timestamp layout and FSM encoding for the PTP slave exchange sequencer.
package ptp_ts_collect_pkg;

    localparam int TS_W       = 48;
    localparam int CYC_W      = 17;
    localparam int MS_W       = 31;
    localparam int CYC_PER_MS = 125000;
    localparam int TMR_W      = 24;

    typedef struct packed {
        logic [MS_W-1:0]  ms;
        logic [CYC_W-1:0] cyc;
    } ts_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DLY  = 3'd1,
        WAIT_TX   = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_e;

    function automatic logic cyc_in_range(input logic [CYC_W-1:0] cyc);
        return cyc < CYC_W'(CYC_PER_MS);
    endfunction

endpackage

// File: rtl/ptp_ts_collect_timer.sv
// Loadable down-counter; done is high in the cycle the count sits at zero, then it stops.
// Latency: load value N gives done N cycles after the load edge; no backpressure.
// Backpressure: none; load overrides clear, which overrides counting.
module ptp_ts_collect_timer
    import ptp_ts_collect_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         running;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= load_val;
            running <= 1'b1;
        end else if (clear || (running && cnt == '0)) begin
            running <= 1'b0;
        end else if (running) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = running && (cnt == '0);

endmodule

// File: rtl/ptp_ts_collect.sv
// Slave-side PTP exchange sequencer: Sync -> Delay_Req -> TX timestamp -> Delay_Resp, emits t1..t4 strobes.
// Latency: ts_2_record/ts_1_valid 1 cycle after Sync, send_dreq DREQ_DELAY cycles after, status_ok 2 after ts_4_valid.
// Backpressure: none; events in unexpected states are dropped. Optional cyc range check: PTP_TS_RANGE_CHECK_EN.
module ptp_ts_collect
    import ptp_ts_collect_pkg::*;
#(
    parameter int DREQ_DELAY  = 16,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int SEQ_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_or_s,
    input  logic             rx_sync_valid,
    input  logic [SEQ_W-1:0] rx_sync_seq,
    input  logic [TS_W-1:0]  rx_sync_ts,
    input  logic             tx_dreq_ts_valid,
    input  logic [TS_W-1:0]  tx_dreq_ts,
    input  logic             rx_dresp_valid,
    input  logic [SEQ_W-1:0] rx_dresp_seq,
    input  logic [TS_W-1:0]  rx_dresp_ts,
    output logic             send_dreq,
    output logic [SEQ_W-1:0] dreq_seq,
    output logic             ts_2_record,
    output logic             ts_1_valid,
    output logic [TS_W-1:0]  ts_1,
    output logic             ts_3_valid,
    output logic [TS_W-1:0]  ts_3,
    output logic             ts_4_valid,
    output logic [TS_W-1:0]  ts_4,
    output logic             status_ok,
    output logic             timeout_err,
    output logic [31:0]      exch_cnt
);

    localparam logic [TMR_W-1:0] DLY_LOAD  = TMR_W'(DREQ_DELAY - 1);
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(1);

    state_e           state, state_nxt;
    logic [SEQ_W-1:0] seq_q;
    logic             t1_ok, t3_ok, t4_ok;
    logic             take_sync, take_tx, take_resp, abort_err, ok_set, dreq_fire;
    logic             dly_load, dly_done, to_done, tmr_clear;
    logic [TMR_W-1:0] dly_val;

`ifdef PTP_TS_RANGE_CHECK_EN
    assign t1_ok = cyc_in_range(rx_sync_ts[CYC_W-1:0]);
    assign t3_ok = cyc_in_range(tx_dreq_ts[CYC_W-1:0]);
    assign t4_ok = cyc_in_range(rx_dresp_ts[CYC_W-1:0]);
`else
    assign t1_ok = 1'b1;
    assign t3_ok = 1'b1;
    assign t4_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_sync = 1'b0;
        take_tx   = 1'b0;
        take_resp = 1'b0;
        abort_err = 1'b0;
        ok_set    = 1'b0;
        dreq_fire = 1'b0;
        if (m_or_s) begin
            state_nxt = IDLE;
        end else if (rx_sync_valid) begin
            // A Sync in any state (re)starts the exchange from scratch.
            if (t1_ok) begin
                take_sync = 1'b1;
                state_nxt = WAIT_DLY;
            end else begin
                abort_err = 1'b1;
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: ;
                WAIT_DLY: begin
                    if (to_done) begin
                        abort_err = 1'b1;
                        state_nxt = IDLE;
                    end else if (dly_done) begin
                        dreq_fire = 1'b1;
                        state_nxt = WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (to_done || (tx_dreq_ts_valid && !t3_ok)) begin
                        abort_err = 1'b1;
                        state_nxt = IDLE;
                    end else if (tx_dreq_ts_valid) begin
                        take_tx   = 1'b1;
                        state_nxt = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (to_done) begin
                        abort_err = 1'b1;
                        state_nxt = IDLE;
                    end else if (rx_dresp_valid && rx_dresp_seq == seq_q) begin
                        if (t4_ok) begin
                            take_resp = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            abort_err = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                DONE: begin
                    if (dly_done) begin
                        ok_set    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The delay timer doubles as the settle counter between ts_4_valid and status_ok.
    assign dly_load  = take_sync || take_resp;
    assign dly_val   = take_resp ? SETTLE_LD : DLY_LOAD;
    assign tmr_clear = (state_nxt == IDLE);

    ptp_ts_collect_timer #(.W(TMR_W)) u_dly_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (dly_load),
        .load_val (dly_val),
        .clear    (tmr_clear),
        .done     (dly_done)
    );

    ptp_ts_collect_timer #(.W(TMR_W)) u_to_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (take_sync),
        .load_val (TO_LOAD),
        .clear    (tmr_clear),
        .done     (to_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_2_record <= 1'b0;
            ts_1_valid  <= 1'b0;
            ts_3_valid  <= 1'b0;
            ts_4_valid  <= 1'b0;
            status_ok   <= 1'b0;
            timeout_err <= 1'b0;
            seq_q       <= '0;
            ts_1        <= '0;
            ts_3        <= '0;
            ts_4        <= '0;
            exch_cnt    <= '0;
        end else begin
            ts_2_record <= take_sync;
            ts_1_valid  <= take_sync;
            ts_3_valid  <= take_tx;
            ts_4_valid  <= take_resp;
            status_ok   <= ok_set;
            timeout_err <= abort_err;
            if (take_sync) begin
                seq_q <= rx_sync_seq;
                ts_1  <= rx_sync_ts;
            end
            if (take_tx) begin
                ts_3 <= tx_dreq_ts;
            end
            if (take_resp) begin
                ts_4 <= rx_dresp_ts;
            end
            if (ok_set) begin
                exch_cnt <= exch_cnt + 32'd1;
            end
        end
    end

    assign send_dreq = dreq_fire;
    assign dreq_seq  = seq_q;

endmodule

// File: tb/tb_ptp_ts_collect.sv
// Scoreboard bench for ptp_ts_collect: stimulus tasks push expected strobes (kind, cycle, value),
// a negedge monitor pops and compares them as the DUT raises its strobes.
module tb_ptp_ts_collect;

    localparam int DLY = 4;
    localparam int TMO = 200;
`ifdef PTP_TS_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    localparam int EV_TS2  = 0;
    localparam int EV_TS1  = 1;
    localparam int EV_DREQ = 2;
    localparam int EV_TS3  = 3;
    localparam int EV_TS4  = 4;
    localparam int EV_OK   = 5;
    localparam int EV_TERR = 6;
    localparam int EV_NONE = 15;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_or_s;
    logic        rx_sync_valid;
    logic [15:0] rx_sync_seq;
    logic [47:0] rx_sync_ts;
    logic        tx_dreq_ts_valid;
    logic [47:0] tx_dreq_ts;
    logic        rx_dresp_valid;
    logic [15:0] rx_dresp_seq;
    logic [47:0] rx_dresp_ts;
    logic        send_dreq;
    logic [15:0] dreq_seq;
    logic        ts_2_record;
    logic        ts_1_valid;
    logic [47:0] ts_1;
    logic        ts_3_valid;
    logic [47:0] ts_3;
    logic        ts_4_valid;
    logic [47:0] ts_4;
    logic        status_ok;
    logic        timeout_err;
    logic [31:0] exch_cnt;

    int  n_err   = 0;
    int  n_chk   = 0;
    int  cyc     = 0;
    int  exp_cnt = 0;
    int  sync_cyc;
    bit  live    = 1'b0;
    ev_t exp_q[$];

    ptp_ts_collect #(
        .DREQ_DELAY  (DLY),
        .TIMEOUT_CYC (TMO),
        .SEQ_W       (16)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .m_or_s           (m_or_s),
        .rx_sync_valid    (rx_sync_valid),
        .rx_sync_seq      (rx_sync_seq),
        .rx_sync_ts       (rx_sync_ts),
        .tx_dreq_ts_valid (tx_dreq_ts_valid),
        .tx_dreq_ts       (tx_dreq_ts),
        .rx_dresp_valid   (rx_dresp_valid),
        .rx_dresp_seq     (rx_dresp_seq),
        .rx_dresp_ts      (rx_dresp_ts),
        .send_dreq        (send_dreq),
        .dreq_seq         (dreq_seq),
        .ts_2_record      (ts_2_record),
        .ts_1_valid       (ts_1_valid),
        .ts_1             (ts_1),
        .ts_3_valid       (ts_3_valid),
        .ts_3             (ts_3),
        .ts_4_valid       (ts_4_valid),
        .ts_4             (ts_4),
        .status_ok        (status_ok),
        .timeout_err      (timeout_err),
        .exch_cnt         (exch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push(input int kind, input int c, input logic [63:0] v);
        ev_t e;
        int  pos;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        pos    = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc * 8 + exp_q[i].kind > c * 8 + kind) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endfunction

    function automatic logic [63:0] ev_val(input int k);
        case (k)
            EV_TS1:         return 64'(ts_1);
            EV_DREQ:        return 64'(dreq_seq);
            EV_TS3:         return 64'(ts_3);
            EV_TS4:         return 64'(ts_4);
            EV_OK, EV_TERR: return 64'(exch_cnt);
            default:        return 64'd0;
        endcase
    endfunction

    task automatic observe(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("ev%0d_kind unexpected", k), k, EV_NONE);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("ev%0d_kind", k), k, e.kind);
            chk($sformatf("ev%0d_cycle", k), cyc, e.cyc);
            chk($sformatf("ev%0d_value", k), ev_val(k), e.val);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [6:0] f;
        f = {timeout_err, status_ok, ts_4_valid, ts_3_valid, send_dreq, ts_1_valid, ts_2_record};
        if (rst_n) begin
            for (int k = 0; k < 7; k++) begin
                if (f[k]) observe(k);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sync(input logic [15:0] seq, input logic [47:0] ts, input bit exp_dreq);
        rx_sync_valid = 1'b1;
        rx_sync_seq   = seq;
        rx_sync_ts    = ts;
        sync_cyc      = cyc;
        if (m_or_s) begin
            live = 1'b0;
        end else if (RANGE_CHK && ts[16:0] >= 17'd125000) begin
            push(EV_TERR, cyc + 1, exp_cnt);
            live = 1'b0;
        end else begin
            push(EV_TS2, cyc + 1, 64'd0);
            push(EV_TS1, cyc + 1, ts);
            if (exp_dreq) push(EV_DREQ, cyc + DLY, seq);
            live = 1'b1;
        end
        tick(1);
        rx_sync_valid = 1'b0;
    endtask

    task automatic send_tx(input logic [47:0] ts, input bit want);
        tx_dreq_ts_valid = 1'b1;
        tx_dreq_ts       = ts;
        if (live && want) push(EV_TS3, cyc + 1, ts);
        tick(1);
        tx_dreq_ts_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [15:0] seq, input logic [47:0] ts, input bit want);
        rx_dresp_valid = 1'b1;
        rx_dresp_seq   = seq;
        rx_dresp_ts    = ts;
        if (live && want) begin
            if (RANGE_CHK && ts[16:0] >= 17'd125000) begin
                push(EV_TERR, cyc + 1, exp_cnt);
            end else begin
                exp_cnt++;
                push(EV_TS4, cyc + 1, ts);
                push(EV_OK, cyc + 3, exp_cnt);
            end
            live = 1'b0;
        end
        tick(1);
        rx_dresp_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, " send_dreq"}, send_dreq, 0);
        chk({pfx, " dreq_seq"}, dreq_seq, 0);
        chk({pfx, " ts_2_record"}, ts_2_record, 0);
        chk({pfx, " ts_1_valid"}, ts_1_valid, 0);
        chk({pfx, " ts_1"}, ts_1, 0);
        chk({pfx, " ts_3_valid"}, ts_3_valid, 0);
        chk({pfx, " ts_4_valid"}, ts_4_valid, 0);
        chk({pfx, " ts_4"}, ts_4, 0);
        chk({pfx, " status_ok"}, status_ok, 0);
        chk({pfx, " timeout_err"}, timeout_err, 0);
        chk({pfx, " exch_cnt"}, exch_cnt, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        m_or_s           = 1'b0;
        rx_sync_valid    = 1'b0;
        rx_sync_seq      = '0;
        rx_sync_ts       = '0;
        tx_dreq_ts_valid = 1'b0;
        tx_dreq_ts       = '0;
        rx_dresp_valid   = 1'b0;
        rx_dresp_seq     = '0;
        rx_dresp_ts      = '0;
        tick(3);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        tick(2);

        // Normal exchange; this t1 has cyc=125000, so the range-check build rejects it.
        send_sync(16'd5, 48'h0000_0001_E848, 1'b1);
        tick(6);
        send_tx(48'h0000_0002_0010, 1'b1);
        tick(3);
        send_resp(16'd5, 48'h0000_0002_0400, 1'b1);
        tick(6);
        chk("normal pending", exp_q.size(), 0);
        chk("normal exch_cnt", exch_cnt, exp_cnt);

        // Mismatched Delay_Resp seq is dropped, matching one completes.
        send_sync(16'd5, 48'h0000_0005_0100, 1'b1);
        tick(6);
        send_tx(48'h0000_0005_0200, 1'b1);
        tick(2);
        send_resp(16'd4, 48'h0000_0005_0AAA, 1'b0);
        tick(2);
        send_resp(16'd5, 48'h0000_0005_0300, 1'b1);
        tick(8);
        chk("mismatch pending", exp_q.size(), 0);
        chk("ts_4 hold", ts_4, 48'h0000_0005_0300);
        chk("ts_1 hold", ts_1, 48'h0000_0005_0100);

        // Timeout: no TX timestamp, no response.
        send_sync(16'd7, 48'h0000_0006_0001, 1'b1);
        push(EV_TERR, sync_cyc + TMO + 1, exp_cnt);
        live = 1'b0;
        tick(TMO + 5);
        send_tx(48'h0000_0006_0002, 1'b1);
        tick(4);
        chk("timeout pending", exp_q.size(), 0);
        chk("timeout exch_cnt", exch_cnt, exp_cnt);

        // Re-sync during WAIT_RESP.
        send_sync(16'd8, 48'h0000_0007_0010, 1'b1);
        tick(6);
        send_tx(48'h0000_0007_0020, 1'b1);
        tick(2);
        send_sync(16'd9, 48'h0000_0007_0100, 1'b1);
        tick(1);
        send_tx(48'h0000_0007_0EEE, 1'b0);
        send_resp(16'd8, 48'h0000_0007_0DDD, 1'b0);
        tick(3);
        chk("resync dreq_seq", dreq_seq, 16'd9);
        send_tx(48'h0000_0007_0200, 1'b1);
        tick(2);
        send_resp(16'd8, 48'h0000_0007_0CCC, 1'b0);
        send_resp(16'd9, 48'h0000_0007_0300, 1'b1);
        tick(8);
        chk("resync pending", exp_q.size(), 0);
        chk("resync exch_cnt", exch_cnt, exp_cnt);

        // Master mode ignores everything; m_or_s mid-exchange aborts silently.
        m_or_s = 1'b1;
        send_sync(16'd3, 48'h0000_0008_0001, 1'b1);
        tick(5);
        send_tx(48'h0000_0008_0002, 1'b1);
        send_resp(16'd3, 48'h0000_0008_0003, 1'b1);
        tick(3);
        m_or_s = 1'b0;
        send_sync(16'd10, 48'h0000_0008_0100, 1'b0);
        m_or_s = 1'b1;
        tick(1);
        m_or_s = 1'b0;
        live   = 1'b0;
        tick(TMO + 10);
        chk("master pending", exp_q.size(), 0);
        chk("master exch_cnt", exch_cnt, exp_cnt);

        // t1 at the last legal cyc; t4 with cyc=125000.
        send_sync(16'd11, 48'h0000_0009_E847, 1'b1);
        tick(6);
        send_tx(48'h0000_0009_0010, 1'b1);
        tick(2);
        send_resp(16'd11, 48'h0000_0003_E848, 1'b1);
        tick(6);
        chk("range pending", exp_q.size(), 0);
        chk("range exch_cnt", exch_cnt, exp_cnt);

        // Reset mid-exchange clears everything with no further strobes.
        send_sync(16'd12, 48'h0000_000A_0010, 1'b0);
        tick(1);
        rst_n   = 1'b0;
        exp_cnt = 0;
        live    = 1'b0;
        tick(2);
        chk_reset_outs("midreset");
        rst_n = 1'b1;
        tick(10);
        chk("midreset pending", exp_q.size(), 0);
        chk("midreset exch_cnt", exch_cnt, exp_cnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ptp_ts_collect.md
Name: ptp_ts_collect

Overview:
- Slave-side PTP exchange sequencer; sits directly upstream of the cycle-sync/offset-correction stage.
- Consumes parsed Sync / Delay_Resp events and MAC TX-timestamp reports, and triggers Delay_Req transmission.
- Delivers t1..t4 strobes plus a single status_ok pulse per completed, sequence-matched exchange.
- Timestamp format throughout: 48 bits, {ms[30:0], cyc[16:0]}; cyc range 0..124999 (125 MHz, 1 ms wrap).

Parameters:
- DREQ_DELAY, 16, clk cycles from Sync acceptance to send_dreq pulse (min 1).
- TIMEOUT_CYC, 2500000, clk cycles allowed from Sync acceptance to Delay_Resp before abort (24-bit counter).
- SEQ_W, 16, width of PTP sequenceId.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  asynchronous, active-low reset.
- m_or_s  in  1  1 = master; block idles and ignores all events when 1.
- rx_sync_valid  in  1  one-cycle strobe: Sync parsed; same cycle as arrival SOF timestamp point.
- rx_sync_seq  in  SEQ_W  Sync sequenceId.
- rx_sync_ts  in  48  originTimestamp carried in Sync (t1).
- tx_dreq_ts_valid  in  1  MAC strobe: Delay_Req left the port.
- tx_dreq_ts  in  48  local departure timestamp (t3).
- rx_dresp_valid  in  1  Delay_Resp parsed.
- rx_dresp_seq  in  SEQ_W  Delay_Resp sequenceId.
- rx_dresp_ts  in  48  receiveTimestamp (t4).
- send_dreq  out  1  one-cycle request to TX path to emit Delay_Req.
- dreq_seq  out  SEQ_W  sequenceId to place in Delay_Req (= accepted Sync seq).
- ts_2_record  out  1  one-cycle strobe; downstream samples its local timer.
- ts_1_valid / ts_1  out  1 / 48  t1 strobe and value.
- ts_3_valid / ts_3  out  1 / 48  t3 strobe and value.
- ts_4_valid / ts_4  out  1 / 48  t4 strobe and value.
- status_ok  out  1  one-cycle pulse: all four timestamps delivered.
- timeout_err  out  1  sticky-for-one-cycle pulse on exchange abort.
- exch_cnt  out  32  count of completed exchanges (wraps).

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, WAIT_DLY, WAIT_TX, WAIT_RESP, DONE.
- IDLE: on rx_sync_valid && !m_or_s, latch seq and t1; next cycle pulse ts_2_record and ts_1_valid together; go WAIT_DLY; start the delay counter and the timeout counter.
- ts_2_record latency fixed at exactly 1 cycle after rx_sync_valid. Downstream compensates; this latency must never vary.
- WAIT_DLY: after DREQ_DELAY cycles, pulse send_dreq (dreq_seq stable from Sync latch until the next Sync acceptance); go WAIT_TX.
- WAIT_TX: on tx_dreq_ts_valid, register t3; pulse ts_3_valid next cycle; go WAIT_RESP.
- WAIT_RESP: on rx_dresp_valid with rx_dresp_seq == latched seq, register t4; pulse ts_4_valid next cycle; go DONE. A mismatched seq is dropped silently; no state change.
- DONE: pulse status_ok exactly 2 cycles after ts_4_valid, so downstream registers are settled; increment exch_cnt; return to IDLE.
- ts_x values hold their last delivered value between strobes.
- Timeout: in WAIT_DLY/WAIT_TX/WAIT_RESP, if the timeout counter reaches TIMEOUT_CYC-1, pulse timeout_err and return to IDLE. No status_ok is issued for that exchange.
- New Sync while not IDLE: restart the exchange. Relatch seq/t1, re-emit ts_2_record/ts_1_valid, reset both counters, go WAIT_DLY. An already-issued send_dreq is not retracted; a late tx_dreq_ts_valid is accepted as t3 of the new exchange only if it arrives in WAIT_TX.
- Events arriving in a state that does not expect them are ignored.
- m_or_s rising mid-exchange: abort to IDLE next cycle; no timeout_err.
- Reset mid-operation: immediate return to reset values; no partial strobes.

Optional Feature:
- Macro PTP_TS_RANGE_CHECK_EN.
- Defined: any t1/t3/t4 input whose cyc field is >= 125000 is treated as corrupt. The exchange aborts to IDLE and timeout_err pulses; status_ok is never issued for it.
- Undefined: no range check; values pass through unchanged.

Decomposition:
- Shared package: timestamp width 48, CYC_W 17, MS_W 31, CYC_PER_MS 125000, state encoding constants.
- One natural sub-module: ptp_ts_collect_timer (loadable down-counter with done strobe), instanced twice, for the delay and the timeout.

Test Plan:
- Normal exchange: Sync seq=5, t1=0x000000_1E848, then tx ts, then Delay_Resp seq=5 -> ts_2_record at +1 cycle, send_dreq at +DREQ_DELAY, status_ok 2 cycles after ts_4_valid, exch_cnt=1.
- Mismatched response: Delay_Resp seq=4 then seq=5 -> first dropped; ts_4 equals the seq=5 value; one status_ok.
- Timeout: Sync then no Delay_Resp for TIMEOUT_CYC cycles -> timeout_err pulse, state IDLE, no status_ok, exch_cnt unchanged.
- Re-sync: second Sync (seq=9) during WAIT_RESP -> ts_1_valid and ts_2_record re-pulse, dreq_seq=9; Delay_Resp seq=8 ignored.
- Master mode: m_or_s=1 with Sync stimulus -> no strobes ever; m_or_s set mid-exchange -> silent abort.
- With PTP_TS_RANGE_CHECK_EN: t4 cyc=125000 -> abort with timeout_err; without the macro -> status_ok issued.
